// File: rtl/tag_slot_scheduler.sv
// tag_slot_scheduler
// Steps through a host-written table of per-slot tag-enable masks. Each slot
// is a fixed number of trigger bursts (SYM_LEN clocks high) separated by gaps
// (GAP_LEN clocks low). The mask for the next slot is fetched in a one-clock
// LOAD state, so the mask can only change while the trigger is low. A stop
// request is latched and honoured only at the end of a gap, so a burst is
// never truncated.
module tag_slot_scheduler #(
  parameter int N_TAGS        = 20,
  parameter int N_SLOTS       = 200,
  parameter int SYMS_PER_SLOT = 10,
  parameter int SYM_LEN       = 800,
  parameter int GAP_LEN       = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_cfg_we,
  input  logic [7:0]        i_cfg_addr,
  input  logic [N_TAGS-1:0] i_cfg_data,
  output logic              o_trigger,
  output logic [N_TAGS-1:0] o_tag_control_sig,
  output logic [7:0]        o_slot_index,
  output logic              o_slot_strobe,
  output logic              o_frame_done,
  output logic              o_busy
);

  // Widths. The phase timer covers the longer of burst and gap; the slot
  // counter addresses the schedule table.
  localparam int LP_MAX_LEN = (SYM_LEN > GAP_LEN) ? SYM_LEN : GAP_LEN;
  localparam int LP_TMR_W   = (LP_MAX_LEN > 2) ? $clog2(LP_MAX_LEN) : 1;
  localparam int LP_SYM_W   = (SYMS_PER_SLOT > 2) ? $clog2(SYMS_PER_SLOT) : 1;
  localparam int LP_ADR_W   = (N_SLOTS > 2) ? $clog2(N_SLOTS) : 1;

  localparam logic [LP_TMR_W-1:0] LP_SYM_LAST  = LP_TMR_W'(SYM_LEN - 1);
  localparam logic [LP_TMR_W-1:0] LP_GAP_LAST  = LP_TMR_W'(GAP_LEN - 1);
  localparam logic [LP_SYM_W-1:0] LP_CNT_LAST  = LP_SYM_W'(SYMS_PER_SLOT - 1);
  localparam logic [7:0]          LP_SLOT_LAST = 8'(N_SLOTS - 1);
  localparam logic [8:0]          LP_SLOT_LIM  = 9'(N_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  // Schedule table (block RAM, not reset)
  logic [N_TAGS-1:0]   r_mem [0:N_SLOTS-1];

  state_t              r_state;
  state_t              w_state_next;
  logic [LP_TMR_W-1:0] r_tmr;
  logic [LP_SYM_W-1:0] r_sym_cnt;
  logic [7:0]          r_slot_idx;
  logic [N_TAGS-1:0]   r_tag;
  logic                r_strobe;
  logic                r_frame_done;
  logic                r_stop_pend;

  logic                w_cfg_hit;
  logic [LP_ADR_W-1:0] w_cfg_addr;
  logic [LP_ADR_W-1:0] w_rd_addr;
  logic                w_sym_end;
  logic                w_gap_end;
  logic                w_stop_now;
  logic                w_start_ok;
  logic                w_last_sym;
  logic                w_next_sym;
  logic                w_next_slot;
  logic                w_halt;
  logic                w_wrap;

  // Addresses outside the table are dropped rather than aliased.
  assign w_cfg_hit  = i_cfg_we && ({1'b0, i_cfg_addr} < LP_SLOT_LIM);
  assign w_cfg_addr = i_cfg_addr[LP_ADR_W-1:0];
  assign w_rd_addr  = r_slot_idx[LP_ADR_W-1:0];

  // Phase decode. A stop seen on the very last gap clock still counts.
  assign w_sym_end   = (r_state == S_ACTIVE) && (r_tmr == LP_SYM_LAST);
  assign w_gap_end   = (r_state == S_GAP) && (r_tmr == LP_GAP_LAST);
  assign w_stop_now  = r_stop_pend | i_stop;
  assign w_start_ok  = (r_state == S_IDLE) && i_start && !i_stop;
  assign w_last_sym  = (r_sym_cnt == LP_CNT_LAST);
  assign w_halt      = w_gap_end && w_stop_now;
  assign w_next_sym  = w_gap_end && !w_stop_now && !w_last_sym;
  assign w_next_slot = w_gap_end && !w_stop_now && w_last_sym;
  assign w_wrap      = (r_slot_idx == LP_SLOT_LAST);

  // Host writes to the schedule table, accepted in any state
  always_ff @(posedge i_clock) begin
    if (w_cfg_hit) begin
      r_mem[w_cfg_addr] <= i_cfg_data;
    end
  end

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    o_trigger    = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_start_ok) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        o_trigger = 1'b1;
        if (w_sym_end) begin
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_halt) begin
          w_state_next = S_IDLE;
        end else if (w_next_sym) begin
          w_state_next = S_ACTIVE;
        end else if (w_next_slot) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Phase timer: counts clocks within a burst or gap, restarts at each phase end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmr <= '0;
    end else if ((r_state == S_ACTIVE) || (r_state == S_GAP)) begin
      if (w_sym_end || w_gap_end) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end else begin
      r_tmr <= '0;
    end
  end

  // Burst counter within a slot and slot index across the frame
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sym_cnt    <= '0;
      r_slot_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start_ok) begin
        r_sym_cnt  <= '0;
        r_slot_idx <= '0;
      end else if (w_next_sym) begin
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end else if (w_next_slot) begin
        r_sym_cnt <= '0;
        if (w_wrap) begin
          r_slot_idx   <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_slot_idx <= r_slot_idx + 1'b1;
        end
      end
    end
  end

  // Mask fetch on LOAD exit; registered read gives read-before-write on a
  // same-cycle host write to the slot being loaded.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tag    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= (r_state == S_LOAD);
      if (r_state == S_LOAD) begin
        r_tag <= r_mem[w_rd_addr];
      end
    end
  end

  // Stop request latch: collected while busy, consumed at the end of a gap
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stop_pend <= 1'b0;
    end else if ((r_state == S_IDLE) || w_halt) begin
      r_stop_pend <= 1'b0;
    end else if (i_stop) begin
      r_stop_pend <= 1'b1;
    end
  end

  assign o_tag_control_sig = r_tag;
  assign o_slot_index      = r_slot_idx;
  assign o_slot_strobe     = r_strobe;
  assign o_frame_done      = r_frame_done;

endmodule

// File: tb/tb_tag_slot_scheduler.sv
// Directed bench for tag_slot_scheduler, built with a 4-slot, 2-burst table
// so a whole frame fits in a short run.
module tb_tag_slot_scheduler;

  localparam int N_TAGS  = 20;
  localparam int N_SLOTS = 4;
  localparam int SPS     = 2;
  localparam int SYM_LEN = 800;
  localparam int GAP_LEN = 16;
  // one slot = LOAD + SPS*(burst+gap) clocks; one frame = 4 slots
  localparam int FRAME_CLKS = 6532;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cfg_we = 1'b0;
  logic [7:0]        cfg_addr = '0;
  logic [N_TAGS-1:0] cfg_data = '0;
  logic              trigger;
  logic [N_TAGS-1:0] tag;
  logic [7:0]        slot_index;
  logic              strobe;
  logic              frame_done;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int tag_viol = 0;

  tag_slot_scheduler #(
    .N_TAGS(N_TAGS), .N_SLOTS(N_SLOTS), .SYMS_PER_SLOT(SPS),
    .SYM_LEN(SYM_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_trigger(trigger), .o_tag_control_sig(tag), .o_slot_index(slot_index),
    .o_slot_strobe(strobe), .o_frame_done(frame_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Watch for the mask moving while a burst is in progress
  logic              mon_trig_q = 1'b0;
  logic [N_TAGS-1:0] mon_tag_q = '0;
  always @(negedge clk) begin
    if (rst_n && trigger && mon_trig_q && (tag !== mon_tag_q)) tag_viol <= tag_viol + 1;
    mon_trig_q <= trigger;
    mon_tag_q  <= tag;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [N_TAGS-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick;
    cfg_we = 1'b0;
    $display("cfg write addr=%0d data=%05h", a, d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_vec++;
    if ({trigger, busy, strobe, frame_done, slot_index, tag} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got trig=%b busy=%b strb=%b fd=%b slot=%0d tag=%05h, expected all 0",
               trigger, busy, strobe, frame_done, slot_index, tag);
    end
    rst_n = 1'b1;
    tick; tick;
    n_vec++;
    if ({trigger, busy, strobe, frame_done, slot_index, tag} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got trig=%b busy=%b slot=%0d tag=%05h, expected idle zeros",
               trigger, busy, slot_index, tag);
    end
    cfg_write(8'd0, 20'h00012);
    cfg_write(8'd1, 20'h00008);
    cfg_write(8'd2, 20'h00001);
    cfg_write(8'd3, 20'h0F00F);
    $display("test_reset done");
  endtask

  task automatic test_first_slot;
    int hi, lo;
    int hi_q[$];
    int lo_q[$];
    logic prev;
    bit done;
    start = 1'b1; tick; start = 1'b0;
    n_vec++;
    if ({busy, trigger, strobe} !== 3'b100 || slot_index !== 8'd0) begin
      n_err++;
      $display("FAIL load_state: got busy=%b trig=%b strb=%b slot=%0d, expected 1 0 0 slot 0",
               busy, trigger, strobe, slot_index);
    end
    tick;
    n_vec++;
    if (tag !== 20'h00012 || strobe !== 1'b1 || trigger !== 1'b1) begin
      n_err++;
      $display("FAIL slot0_mask: got tag=%05h strb=%b trig=%b, expected 00012 1 1", tag, strobe, trigger);
    end
    prev = 1'b1; hi = 1; lo = 0; done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tick;
      if (trigger) begin
        if (!prev) begin lo_q.push_back(lo); lo = 0; end
        hi++;
      end else begin
        if (prev) begin hi_q.push_back(hi); hi = 0; end
        lo++;
      end
      prev = trigger;
      if (strobe) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL slot1_timeout: got no strobe in 4000 clks, expected strobe for slot 1");
    end
    n_vec++;
    if (hi_q.size() != 2 || hi_q[0] != SYM_LEN || hi_q[1] != SYM_LEN) begin
      n_err++;
      $display("FAIL burst_len: got %0d bursts first=%0d second=%0d, expected 2 bursts of 800",
               hi_q.size(), hi_q[0], hi_q[1]);
    end
    n_vec++;
    if (lo_q.size() != 2 || lo_q[0] != 16 || lo_q[1] != 17) begin
      n_err++;
      $display("FAIL gap_len: got %0d gaps %0d,%0d, expected 16 (in-slot) then 17 (gap+LOAD)",
               lo_q.size(), lo_q[0], lo_q[1]);
    end
    n_vec++;
    if (tag !== 20'h00008 || slot_index !== 8'd1) begin
      n_err++;
      $display("FAIL slot1_mask: got tag=%05h slot=%0d, expected 00008 slot 1", tag, slot_index);
    end
    $display("test_first_slot done");
  endtask

  task automatic test_frame;
    bit found;
    int strobes, exp_slot, seq_bad, width_bad, clks;
    logic prev_fd;
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      tick;
      if (frame_done) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL frame_timeout: got no frame_done, expected one within a frame");
    end
    n_vec++;
    if (slot_index !== 8'd0 || tag !== 20'h0F00F || trigger !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_state: got slot=%0d tag=%05h trig=%b busy=%b, expected 0 0F00F 0 1",
               slot_index, tag, trigger, busy);
    end
    strobes = 0; exp_slot = 0; seq_bad = 0; width_bad = 0; clks = 0;
    prev_fd = 1'b1; found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      tick;
      clks++;
      if (frame_done && prev_fd) width_bad++;
      prev_fd = frame_done;
      if (strobe) begin
        if (slot_index !== 8'(exp_slot)) seq_bad++;
        exp_slot = (exp_slot + 1) % N_SLOTS;
        strobes++;
      end
      if (frame_done) found = 1'b1;
    end
    n_vec++;
    if (strobes != 4 || seq_bad != 0) begin
      n_err++;
      $display("FAIL frame_strobes: got %0d strobes %0d out of order, expected 4 in order 0..3",
               strobes, seq_bad);
    end
    n_vec++;
    if (clks != FRAME_CLKS || width_bad != 0) begin
      n_err++;
      $display("FAIL frame_period: got %0d clks (%0d wide pulses), expected %0d clks single pulse",
               clks, width_bad, FRAME_CLKS);
    end
    tick;
    n_vec++;
    if (frame_done !== 1'b0 || strobe !== 1'b1 || tag !== 20'h00012) begin
      n_err++;
      $display("FAIL frame_restart: got fd=%b strb=%b tag=%05h, expected 0 1 00012",
               frame_done, strobe, tag);
    end
    $display("test_frame done");
  endtask

  task automatic test_stop;
    int rises, hi, lo;
    logic prev;
    bit done;
    rises = 0; prev = 1'b1;
    for (int i = 0; i < 4000 && rises < 2; i++) begin
      tick;
      if (trigger && !prev) rises++;
      prev = trigger;
    end
    hi = 1;
    for (int i = 0; i < 49; i++) begin
      tick;
      if (trigger) hi++;
    end
    // start while busy must not restart the sequence
    start = 1'b1; tick; start = 1'b0;
    if (trigger) hi++;
    n_vec++;
    if (slot_index !== 8'd1 || strobe !== 1'b0 || trigger !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_busy: got slot=%0d strb=%b trig=%b busy=%b, expected 1 0 1 1",
               slot_index, strobe, trigger, busy);
    end
    stop = 1'b1; tick; stop = 1'b0;
    if (trigger) hi++;
    lo = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick;
      if (!busy) done = 1'b1;
      else if (trigger) hi++;
      else lo++;
    end
    n_vec++;
    if (!done || hi != SYM_LEN || lo != GAP_LEN) begin
      n_err++;
      $display("FAIL stop_timing: got idle=%b burst=%0d gap=%0d, expected idle after 800 high then 16 low",
               done, hi, lo);
    end
    n_vec++;
    if (tag !== 20'h00008 || slot_index !== 8'd1 || trigger !== 1'b0) begin
      n_err++;
      $display("FAIL stop_hold: got tag=%05h slot=%0d trig=%b, expected 00008 1 0", tag, slot_index, trigger);
    end
    for (int i = 0; i < 20; i++) tick;
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    tick;
    n_vec++;
    if (busy !== 1'b0 || tag !== 20'h00008) begin
      n_err++;
      $display("FAIL start_and_stop: got busy=%b tag=%05h, expected 0 00008", busy, tag);
    end
    start = 1'b1; tick; start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || slot_index !== 8'd0 || trigger !== 1'b0) begin
      n_err++;
      $display("FAIL restart_load: got busy=%b slot=%0d trig=%b, expected 1 0 0", busy, slot_index, trigger);
    end
    tick;
    n_vec++;
    if (tag !== 20'h00012 || strobe !== 1'b1) begin
      n_err++;
      $display("FAIL restart_mask: got tag=%05h strb=%b, expected 00012 1", tag, strobe);
    end
    stop = 1'b1; tick; stop = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick;
      if (!busy) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL restart_stop: got busy still high, expected idle after current gap");
    end
    $display("test_stop done");
  endtask

  task automatic test_rbw;
    bit done;
    start = 1'b1; tick; start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      tick;
      if (slot_index == 8'd2) done = 1'b1;
    end
    n_vec++;
    if (!done || trigger !== 1'b0) begin
      n_err++;
      $display("FAIL rbw_reach: got reached=%b trig=%b, expected LOAD of slot 2", done, trigger);
    end
    cfg_we = 1'b1; cfg_addr = 8'd2; cfg_data = 20'hABCDE;
    tick;
    cfg_we = 1'b0;
    $display("cfg write addr=2 data=abcde during LOAD");
    n_vec++;
    if (tag !== 20'h00001 || strobe !== 1'b1) begin
      n_err++;
      $display("FAIL rbw_old: got tag=%05h strb=%b, expected old 00001 1", tag, strobe);
    end
    cfg_write(8'd250, 20'hFFFFF);
    done = 1'b0;
    for (int i = 0; i < 8000 && !done; i++) begin
      tick;
      if (strobe && slot_index == 8'd2) done = 1'b1;
    end
    n_vec++;
    if (!done || tag !== 20'hABCDE) begin
      n_err++;
      $display("FAIL rbw_new: got reached=%b tag=%05h, expected ABCDE next frame", done, tag);
    end
    stop = 1'b1; tick; stop = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick;
      if (!busy) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL rbw_stop: got busy still high, expected idle");
    end
    $display("test_rbw done");
  endtask

  task automatic test_async_reset;
    bit done;
    start = 1'b1; tick; start = 1'b0;
    tick;
    for (int i = 0; i < 100; i++) tick;
    n_vec++;
    if (trigger !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got trig=%b busy=%b, expected 1 1", trigger, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({trigger, busy, strobe, frame_done, slot_index, tag} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got trig=%b busy=%b slot=%0d tag=%05h, expected all 0 before next edge",
               trigger, busy, slot_index, tag);
    end
    #3 rst_n = 1'b1;
    tick;
    start = 1'b1; tick; start = 1'b0;
    tick;
    n_vec++;
    if (tag !== 20'h00012 || strobe !== 1'b1 || slot_index !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset_mask: got tag=%05h strb=%b slot=%0d, expected 00012 1 0",
               tag, strobe, slot_index);
    end
    stop = 1'b1; tick; stop = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick;
      if (!busy) done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL post_reset_stop: got busy still high, expected idle");
    end
    $display("test_async_reset done");
  endtask

  task automatic test_checker;
    n_vec++;
    if (tag_viol != 0) begin
      n_err++;
      $display("FAIL mask_during_burst: got %0d mask changes while trigger high, expected 0", tag_viol);
    end
    $display("test_checker done");
  endtask

  initial begin
    test_reset;
    test_first_slot;
    test_frame;
    test_stop;
    test_rbw;
    test_async_reset;
    test_checker;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
